// File: rtl/heap_array_pkg.sv
// Shared op encoding, FSM state codes and width helpers for the heap array controller.
package heap_array_pkg;

   typedef enum logic [2:0] {
      OP_ALLOC = 3'd0,
      OP_FREE  = 3'd1,
      OP_PUSH  = 3'd2,
      OP_POP   = 3'd3,
      OP_LEN   = 3'd4
   } heap_op_e;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Bits needed to hold every value from 0 up to and including n.
   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int size_width(input int narea);
      return count_width(narea);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/heap_free_stack.sv
// LIFO of freed array indices; push/pop take effect at the clock edge, top is combinational.
module heap_free_stack
   import heap_array_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] top,
   output logic              empty,
   output logic              full
);

   localparam int CNT_W = count_width(DEPTH);
   localparam int PTR_W = idx_width(DEPTH);

   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] entry_q [DEPTH];
   logic [DATA_W-1:0] entry_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, top_ptr;

   assign wr_ptr  = count_q[PTR_W-1:0];
   assign top_ptr = PTR_W'(count_q - CNT_W'(1));
   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign top     = empty ? '0 : entry_q[top_ptr];

   // Overflowing pushes and underflowing pops are dropped so the count never wraps.
   always_comb begin
      count_d = count_q;
      entry_d = entry_q;
      if (push && !full) begin
         entry_d[wr_ptr] = push_data;
         count_d         = count_q + CNT_W'(1);
      end else if (pop && !empty) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
         entry_q <= '{default: '0};
      end else begin
         count_q <= count_d;
         entry_q <= entry_d;
      end
   end

endmodule

// File: rtl/heap_array_ctrl.sv
// Heap array controller: size table, allocation counter, freed-index LIFO and heap sequencing.
// Define HEAP_ARRAY_CHECK_EN to enable command error checking and rsp_error.
module heap_array_ctrl
   import heap_array_pkg::*;
#(
   parameter int WIDTH   = 12,
   parameter int NARRAYS = 4,
   parameter int NAREA   = 4,
   parameter int ADDR_W  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [WIDTH-1:0]  cmd_array,
   input  logic [WIDTH-1:0]  cmd_data,
   output logic              rsp_valid,
   output logic [WIDTH-1:0]  rsp_data,
   output logic              rsp_error,
   output logic              heap_write,
   output logic [ADDR_W-1:0] heap_address,
   output logic [WIDTH-1:0]  heap_in,
   input  logic [WIDTH-1:0]  heap_out
);

   localparam int SIZE_W = size_width(NAREA);
   localparam int IDX_W  = idx_width(NARRAYS);
   localparam int CNT_W  = count_width(NARRAYS);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  allocs_q, allocs_d, allocs_next;
   logic [SIZE_W-1:0] size_q [NARRAYS];
   logic [SIZE_W-1:0] size_d [NARRAYS];
   logic [NARRAYS-1:0] alloc_q, alloc_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic              rsp_error_q, rsp_error_d;
   logic              pop_rsp_q, pop_rsp_d;
   logic              heap_write_q, heap_write_d;
   logic [ADDR_W-1:0] heap_address_q, heap_address_d;
   logic [WIDTH-1:0]  heap_in_q, heap_in_d;

   logic [IDX_W-1:0]  arr_idx, new_idx, fs_top;
   logic [SIZE_W-1:0] cur_size, new_size;
   logic              fs_push, fs_pop, fs_empty, fs_full;
   logic              cmd_err;

   assign arr_idx  = cmd_array[IDX_W-1:0];
   assign cur_size = size_q[arr_idx];

   heap_free_stack #(
      .DEPTH  (NARRAYS),
      .DATA_W (IDX_W)
   ) u_free_stack (
      .clock     (clock),
      .reset     (reset),
      .push      (fs_push),
      .pop       (fs_pop),
      .push_data (arr_idx),
      .top       (fs_top),
      .empty     (fs_empty),
      .full      (fs_full)
   );

`ifdef HEAP_ARRAY_CHECK_EN
   logic arr_bad;

   assign arr_bad     = (cmd_array >= WIDTH'(NARRAYS)) || !alloc_q[arr_idx];
   assign allocs_next = allocs_q + CNT_W'(1);

   always_comb begin
      case (cmd_op)
         OP_ALLOC:        cmd_err = (allocs_q == CNT_W'(NARRAYS)) && fs_empty;
         OP_FREE, OP_LEN: cmd_err = arr_bad;
         OP_PUSH:         cmd_err = arr_bad || (cur_size == SIZE_W'(NAREA));
         OP_POP:          cmd_err = arr_bad || (cur_size == '0);
         default:         cmd_err = 1'b1;
      endcase
   end
`else
   // Unchecked builds recycle array indices once the counter passes the last array.
   assign cmd_err     = 1'b0;
   assign allocs_next = (allocs_q >= CNT_W'(NARRAYS - 1)) ? '0 : allocs_q + CNT_W'(1);
`endif

   // Every response and heap port is registered here; only POP data comes straight from heap_out.
   always_comb begin
      state_d        = state_q;
      allocs_d       = allocs_q;
      size_d         = size_q;
      alloc_d        = alloc_q;
      rsp_valid_d    = 1'b0;
      rsp_data_d     = '0;
      rsp_error_d    = 1'b0;
      pop_rsp_d      = 1'b0;
      heap_write_d   = 1'b0;
      heap_address_d = heap_address_q;
      heap_in_d      = heap_in_q;
      fs_push        = 1'b0;
      fs_pop         = 1'b0;
      new_idx        = '0;
      new_size       = cur_size;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_err) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
               end else begin
                  case (cmd_op)
                     OP_ALLOC: begin
                        if (!fs_empty) begin
                           new_idx = fs_top;
                           fs_pop  = 1'b1;
                        end else begin
                           new_idx  = allocs_q[IDX_W-1:0];
                           allocs_d = allocs_next;
                        end
                        size_d[new_idx]  = '0;
                        alloc_d[new_idx] = 1'b1;
                        rsp_data_d       = WIDTH'(new_idx);
                        rsp_valid_d      = 1'b1;
                        state_d          = ST_RESP;
                     end
                     OP_FREE: begin
                        fs_push          = !fs_full;
                        size_d[arr_idx]  = '0;
                        alloc_d[arr_idx] = 1'b0;
                        rsp_valid_d      = 1'b1;
                        state_d          = ST_RESP;
                     end
                     OP_PUSH: begin
                        heap_write_d    = 1'b1;
                        heap_address_d  = ADDR_W'(32'(cmd_array) * NAREA + 32'(cur_size));
                        heap_in_d       = cmd_data;
                        size_d[arr_idx] = cur_size + SIZE_W'(1);
                        rsp_valid_d     = 1'b1;
                        state_d         = ST_WRITE;
                     end
                     OP_POP: begin
                        new_size        = cur_size - SIZE_W'(1);
                        size_d[arr_idx] = new_size;
                        heap_address_d  = ADDR_W'(32'(cmd_array) * NAREA + 32'(new_size));
                        state_d         = ST_READ;
                     end
                     OP_LEN: begin
                        rsp_data_d  = WIDTH'(cur_size);
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                     end
                     default: begin
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                     end
                  endcase
               end
            end
         end
         ST_READ: begin
            rsp_valid_d = 1'b1;
            pop_rsp_d   = 1'b1;
            state_d     = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         allocs_q       <= '0;
         size_q         <= '{default: '0};
         alloc_q        <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= '0;
         rsp_error_q    <= 1'b0;
         pop_rsp_q      <= 1'b0;
         heap_write_q   <= 1'b0;
         heap_address_q <= '0;
         heap_in_q      <= '0;
      end else begin
         state_q        <= state_d;
         allocs_q       <= allocs_d;
         size_q         <= size_d;
         alloc_q        <= alloc_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_data_q     <= rsp_data_d;
         rsp_error_q    <= rsp_error_d;
         pop_rsp_q      <= pop_rsp_d;
         heap_write_q   <= heap_write_d;
         heap_address_q <= heap_address_d;
         heap_in_q      <= heap_in_d;
      end
   end

   assign cmd_ready    = (state_q == ST_IDLE);
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = pop_rsp_q ? heap_out : rsp_data_q;
   assign rsp_error    = rsp_error_q;
   assign heap_write   = heap_write_q;
   assign heap_address = heap_address_q;
   assign heap_in      = heap_in_q;

endmodule

// File: tb/tb_heap_array_ctrl.sv
// Directed, table-driven bench for heap_array_ctrl with a one-cycle-latency heap memory model.
// Expectations follow HEAP_ARRAY_CHECK_EN when the bench is built with that macro.
module tb_heap_array_ctrl;

   localparam int WIDTH   = 12;
   localparam int NARRAYS = 4;
   localparam int NAREA   = 4;
   localparam int ADDR_W  = 4;

   localparam logic [2:0] C_ALLOC = 3'd0;
   localparam logic [2:0] C_FREE  = 3'd1;
   localparam logic [2:0] C_PUSH  = 3'd2;
   localparam logic [2:0] C_POP   = 3'd3;
   localparam logic [2:0] C_LEN   = 3'd4;
   localparam logic [2:0] C_BAD   = 3'd5;

`ifdef HEAP_ARRAY_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   typedef struct {
      logic [2:0]        op;
      logic [WIDTH-1:0]  arr;
      logic [WIDTH-1:0]  data;
      logic [WIDTH-1:0]  exp_data;
      logic              exp_err;
      logic              exp_write;
      logic [ADDR_W-1:0] exp_addr;
      int                exp_lat;
   } vec_t;

   logic              clock;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [WIDTH-1:0]  cmd_array;
   logic [WIDTH-1:0]  cmd_data;
   logic              rsp_valid;
   logic [WIDTH-1:0]  rsp_data;
   logic              rsp_error;
   logic              heap_write;
   logic [ADDR_W-1:0] heap_address;
   logic [WIDTH-1:0]  heap_in;
   logic [WIDTH-1:0]  heap_out;

   logic [WIDTH-1:0]  heap_mem [2**ADDR_W];
   int                tests_run = 0;
   int                tests_failed = 0;
   vec_t              vecs[$];

   heap_array_ctrl #(
      .WIDTH   (WIDTH),
      .NARRAYS (NARRAYS),
      .NAREA   (NAREA),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_array    (cmd_array),
      .cmd_data     (cmd_data),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_error    (rsp_error),
      .heap_write   (heap_write),
      .heap_address (heap_address),
      .heap_in      (heap_in),
      .heap_out     (heap_out)
   );

   // Free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous heap memory: read data appears the cycle after the address
   always @(posedge clock) begin
      if (heap_write) heap_mem[heap_address] <= heap_in;
      heap_out <= heap_mem[heap_address];
   end

   function automatic vec_t mk(input logic [2:0] op, input logic [WIDTH-1:0] arr,
                               input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] exp_data,
                               input logic exp_err, input logic exp_write,
                               input logic [ADDR_W-1:0] exp_addr);
      vec_t v;
      v.op        = op;
      v.arr       = arr;
      v.data      = data;
      v.exp_data  = exp_data;
      v.exp_err   = exp_err;
      v.exp_write = exp_write;
      v.exp_addr  = exp_addr;
      v.exp_lat   = (op == C_POP && !exp_err) ? 2 : 1;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Issue one command from a negedge and check its single response pulse
   task automatic applyStimulus(input vec_t v, input int idx);
      int    waited;
      int    lat;
      string tag;
      tag    = $sformatf("vec%0d op%0d", idx, v.op);
      waited = 0;
      while (!cmd_ready && waited < 10) begin
         @(negedge clock);
         waited++;
      end
      checkOutput({tag, " cmd_ready"}, cmd_ready, 1);
      if (!cmd_ready) return;
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_array = v.arr;
      cmd_data  = v.data;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_array = '0;
      cmd_data  = '0;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
         if (!rsp_valid) begin
            checkOutput({tag, " heap_write before rsp"}, heap_write, 0);
            if (v.exp_lat == 2 && lat == 1)
               checkOutput({tag, " read address"}, heap_address, v.exp_addr);
         end
      end while (!rsp_valid && lat < 6);
      checkOutput({tag, " rsp_valid"}, rsp_valid, 1);
      checkOutput({tag, " latency"}, lat, v.exp_lat);
      checkOutput({tag, " rsp_data"}, rsp_data, v.exp_data);
      checkOutput({tag, " rsp_error"}, rsp_error, v.exp_err);
      checkOutput({tag, " heap_write"}, heap_write, v.exp_write);
      if (v.exp_write) begin
         checkOutput({tag, " write address"}, heap_address, v.exp_addr);
         checkOutput({tag, " write data"}, heap_in, v.data);
      end
      @(negedge clock);
      checkOutput({tag, " rsp pulse end"}, rsp_valid, 0);
      checkOutput({tag, " ready after rsp"}, cmd_ready, 1);
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_array = '0;
      cmd_data  = '0;
      repeat (3) @(negedge clock);

      checkOutput("reset cmd_ready", cmd_ready, 1);
      checkOutput("reset rsp_valid", rsp_valid, 0);
      checkOutput("reset rsp_data", rsp_data, 0);
      checkOutput("reset rsp_error", rsp_error, 0);
      checkOutput("reset heap_write", heap_write, 0);
      checkOutput("reset heap_address", heap_address, 0);
      checkOutput("reset heap_in", heap_in, 0);
      reset = 1'b0;
      @(negedge clock);

      //                op       arr    data    exp_data err  wr    addr
      vecs.push_back(mk(C_ALLOC, 12'd0, 12'd0,  12'd0,   0,   0,    4'd0));
      vecs.push_back(mk(C_PUSH,  12'd0, 12'd1,  12'd0,   0,   1,    4'd0));
      vecs.push_back(mk(C_PUSH,  12'd0, 12'd2,  12'd0,   0,   1,    4'd1));
      vecs.push_back(mk(C_LEN,   12'd0, 12'd0,  12'd2,   0,   0,    4'd0));
      vecs.push_back(mk(C_POP,   12'd0, 12'd0,  12'd2,   0,   0,    4'd1));
      vecs.push_back(mk(C_POP,   12'd0, 12'd0,  12'd1,   0,   0,    4'd0));
      vecs.push_back(mk(C_LEN,   12'd0, 12'd0,  12'd0,   0,   0,    4'd0));
`ifdef HEAP_ARRAY_CHECK_EN
      vecs.push_back(mk(C_POP,   12'd0, 12'd0,  12'd0,   1,   0,    4'd0));
      vecs.push_back(mk(C_LEN,   12'd0, 12'd0,  12'd0,   0,   0,    4'd0));
`endif
      vecs.push_back(mk(C_ALLOC, 12'd0, 12'd0,  12'd1,   0,   0,    4'd0));
      vecs.push_back(mk(C_FREE,  12'd0, 12'd0,  12'd0,   0,   0,    4'd0));
      vecs.push_back(mk(C_ALLOC, 12'd0, 12'd0,  12'd0,   0,   0,    4'd0));
      vecs.push_back(mk(C_LEN,   12'd0, 12'd0,  12'd0,   0,   0,    4'd0));
      vecs.push_back(mk(C_PUSH,  12'd1, 12'd10, 12'd0,   0,   1,    4'd4));
      vecs.push_back(mk(C_PUSH,  12'd1, 12'd11, 12'd0,   0,   1,    4'd5));
      vecs.push_back(mk(C_PUSH,  12'd1, 12'd12, 12'd0,   0,   1,    4'd6));
      vecs.push_back(mk(C_PUSH,  12'd1, 12'd13, 12'd0,   0,   1,    4'd7));
      vecs.push_back(mk(C_LEN,   12'd1, 12'd0,  12'd4,   0,   0,    4'd0));
`ifdef HEAP_ARRAY_CHECK_EN
      vecs.push_back(mk(C_PUSH,  12'd1, 12'd99, 12'd0,   1,   0,    4'd0));
      vecs.push_back(mk(C_LEN,   12'd1, 12'd0,  12'd4,   0,   0,    4'd0));
`endif
      vecs.push_back(mk(C_POP,   12'd1, 12'd0,  12'd13,  0,   0,    4'd7));
      vecs.push_back(mk(C_LEN,   12'd1, 12'd0,  12'd3,   0,   0,    4'd0));
      vecs.push_back(mk(C_ALLOC, 12'd0, 12'd0,  12'd2,   0,   0,    4'd0));
      vecs.push_back(mk(C_ALLOC, 12'd0, 12'd0,  12'd3,   0,   0,    4'd0));
      vecs.push_back(mk(C_ALLOC, 12'd0, 12'd0,  12'd0,   CHK, 0,    4'd0));
      vecs.push_back(mk(C_BAD,   12'd1, 12'd7,  12'd0,   CHK, 0,    4'd0));
`ifdef HEAP_ARRAY_CHECK_EN
      vecs.push_back(mk(C_FREE,  12'd7, 12'd0,  12'd0,   1,   0,    4'd0));
`endif
      vecs.push_back(mk(C_LEN,   12'd1, 12'd0,  12'd3,   0,   0,    4'd0));

      foreach (vecs[i]) applyStimulus(vecs[i], i);

      // Reset while a POP is waiting on heap read data must drop the response
      cmd_valid = 1'b1;
      cmd_op    = C_POP;
      cmd_array = 12'd1;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_array = '0;
      @(negedge clock);
      checkOutput("abort in READ rsp_valid", rsp_valid, 0);
      checkOutput("abort in READ cmd_ready", cmd_ready, 0);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("abort rsp_valid", rsp_valid, 0);
      checkOutput("abort heap_write", heap_write, 0);
      checkOutput("abort cmd_ready", cmd_ready, 1);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checkOutput($sformatf("post abort quiet %0d", k), rsp_valid, 0);
      end
      applyStimulus(mk(C_LEN,   12'd1, 12'd0, 12'd0, CHK, 0, 4'd0), 100);
      applyStimulus(mk(C_LEN,   12'd3, 12'd0, 12'd0, CHK, 0, 4'd0), 101);
      applyStimulus(mk(C_ALLOC, 12'd0, 12'd0, 12'd0, 0,   0, 4'd0), 102);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
